// File: rtl/memory_arbiter_pkg.sv
// Shared memory-side types: bus word, RAM handshake state, arbiter state.
// Imported by the cache control interface and the arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache <-> memory-controller control bundle.
// cc is the controller end; caches is the cache/RAM end.
interface cache_control_if;
    import cpu_types_pkg::*;

    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      ccwait, ccinv;
    word_t     ccsnoopaddr;
    logic      ccwrite, cctrans;

    modport cc (
        input  iREN, dREN, dWEN,
        input  iaddr, daddr, dstore,
        input  ramload, ramstate,
        input  ccwrite, cctrans,
        output iwait, dwait, iload, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output ccwait, ccinv, ccsnoopaddr
    );

    modport caches (
        output iREN, dREN, dWEN,
        output iaddr, daddr, dstore,
        output ramload, ramstate,
        output ccwrite, cctrans,
        input  iwait, dwait, iload, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  ccwait, ccinv, ccsnoopaddr
    );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache, dcache-first
// with a starvation cap that forces an icache grant.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic       CLK,
    input logic       nRST,
    cache_control_if.cc ccif
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CMAX = cnt_t'(STARVE_MAX);

    arb_state_t state_q, state_d, st;
    cnt_t       starve_q, starve_d;
    logic       dreq, acc;

    assign dreq = ccif.dREN | ccif.dWEN;
    assign acc  = (ccif.ramstate == ACCESS);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (ccif.iREN && starve_q == CMAX) begin
                    state_d  = IGRANT;
                    starve_d = '0;
                end else if (dreq) begin
                    state_d = DGRANT;
                    if (ccif.iREN && starve_q != CMAX)
                        starve_d = starve_q + cnt_t'(1);
                end else if (ccif.iREN) begin
                    state_d  = IGRANT;
                    starve_d = '0;
                end
            end
            DGRANT: if (!dreq || acc) state_d = IDLE;
            IGRANT: if (!ccif.iREN || acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Decode as IDLE while reset is held so no wait can drop mid-reset.
    assign st = nRST ? state_q : IDLE;

    always_comb begin
        ccif.iwait    = 1'b1;
        ccif.dwait    = 1'b1;
        ccif.ramREN   = 1'b0;
        ccif.ramWEN   = 1'b0;
        ccif.ramaddr  = '0;
        ccif.ramstore = '0;
        unique case (st)
            DGRANT: begin
                ccif.ramaddr  = ccif.daddr;
                ccif.ramstore = ccif.dstore;
                ccif.ramWEN   = ccif.dWEN;
                ccif.ramREN   = ccif.dREN & ~ccif.dWEN;
                ccif.dwait    = ~acc;
            end
            IGRANT: begin
                ccif.ramaddr = ccif.iaddr;
                ccif.ramREN  = 1'b1;
                ccif.iwait   = ~acc;
            end
            default: ;
        endcase
    end

    assign ccif.iload       = ccif.ramload;
    assign ccif.dload       = ccif.ramload;
    assign ccif.ccwait      = 1'b0;
    assign ccif.ccinv       = 1'b0;
    assign ccif.ccsnoopaddr = '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed table, starvation
// sequence, and randomized traffic against a transfer-level model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int SM = 4;
    localparam word_t IA = 32'h0000_0100;
    localparam word_t DS = 32'h1234_5678;
    localparam word_t LD = 32'hDEAD_BEEF;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cache_control_if ccif();

    memory_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .ccif(ccif)
    );

    typedef struct {
        logic      rn, ir, dr, dw;
        ramstate_t rs;
        word_t     da;
        logic      ei, ed, er, ew;
        word_t     ea;
    } vec_t;

    vec_t tbl[$];

    // model: owner 0 none, 1 dcache, 2 icache; k = dcache grants
    // taken while icache was waiting
    int m_own = 0;
    int m_k = 0;

    function automatic vec_t v(logic rn, ir, dr, dw, ramstate_t rs,
                               word_t da, logic ei, ed, er, ew,
                               word_t ea);
        vec_t t;
        t.rn = rn; t.ir = ir; t.dr = dr; t.dw = dw; t.rs = rs;
        t.da = da; t.ei = ei; t.ed = ed; t.er = er; t.ew = ew;
        t.ea = ea;
        return t;
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rn, ir, dr, dw, ramstate_t rs,
                         word_t ia, da, ds, ld);
        nRST          = rn;
        ccif.iREN     = ir;
        ccif.dREN     = dr;
        ccif.dWEN     = dw;
        ccif.ramstate = rs;
        ccif.iaddr    = ia;
        ccif.daddr    = da;
        ccif.dstore   = ds;
        ccif.ramload  = ld;
    endtask

    task automatic model_edge();
        logic ir, dq, ac;
        ir = ccif.iREN;
        dq = ccif.dREN | ccif.dWEN;
        ac = (ccif.ramstate == ACCESS);
        if (!nRST) begin
            m_own = 0;
            m_k = 0;
        end else if (m_own == 0) begin
            if (m_k == SM && ir) begin
                m_own = 2; m_k = 0;
            end else if (dq) begin
                m_own = 1;
                if (ir && m_k < SM) m_k++;
            end else if (ir) begin
                m_own = 2; m_k = 0;
            end
        end else if (m_own == 1) begin
            if (!dq || ac) m_own = 0;
        end else begin
            if (!ir || ac) m_own = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    function automatic logic [255:0] pack_out(
        logic iw, dw, rr, rw, word_t ra, rst_v, il, dl,
        logic cw, ci, word_t sa);
        return {52'd0, iw, dw, rr, rw, ra, rst_v, il, dl, cw, ci, sa,
                42'd0};
    endfunction

    initial begin
        logic ir, dr, dw, rn;
        ramstate_t rs;
        word_t ia, da, ds, ld;
        logic eiw, edw, err, ewr;
        word_t ea, es;
        int dn;
        logic got;

        ccif.ccwrite = 1'b0;
        ccif.cctrans = 1'b0;
        drive(0, 0, 0, 0, FREE, IA, 0, DS, LD);

        tbl.push_back(v(0,0,0,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(0,1,1,0,ACCESS,32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,BUSY,  32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,1,0,BUSY,  32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,1,0,ACCESS,32'h40,1,0,1,0,32'h40));
        tbl.push_back(v(1,0,0,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,ERROR, 32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,1,0,ERROR, 32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,1,0,ERROR, 32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,1,0,ACCESS,32'h40,1,0,1,0,32'h40));
        tbl.push_back(v(1,0,0,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,0,BUSY,  32'h40,1,1,1,0,32'h40));
        tbl.push_back(v(1,0,0,0,BUSY,  32'h40,1,1,0,0,32'h40));
        tbl.push_back(v(1,0,0,0,ACCESS,32'h40,1,1,0,0,0));
        tbl.push_back(v(1,1,0,1,FREE,  32'h80,1,1,0,0,0));
        tbl.push_back(v(1,1,0,1,ACCESS,32'h80,1,0,0,1,32'h80));
        tbl.push_back(v(1,1,0,0,FREE,  32'h80,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,ACCESS,32'h80,0,1,1,0,IA));
        tbl.push_back(v(1,0,0,0,FREE,  32'h80,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,1,1,0,BUSY,  32'h40,1,1,1,0,IA));
        tbl.push_back(v(0,1,0,0,ACCESS,32'h40,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,ACCESS,32'h40,1,1,0,0,0));
        tbl.push_back(v(1,1,0,0,ACCESS,32'h40,0,1,1,0,IA));
        tbl.push_back(v(1,0,0,0,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,1,FREE,  32'h40,1,1,0,0,0));
        tbl.push_back(v(1,0,1,1,ACCESS,32'h40,1,0,0,1,32'h40));
        tbl.push_back(v(1,0,0,0,FREE,  32'h40,1,1,0,0,0));

        @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rn, tbl[i].ir, tbl[i].dr, tbl[i].dw,
                  tbl[i].rs, IA, tbl[i].da, DS, LD);
            #4;
            chk($sformatf("vec%0d", i),
                {ccif.iwait, ccif.dwait, ccif.ramREN, ccif.ramWEN,
                 ccif.ramaddr},
                {tbl[i].ei, tbl[i].ed, tbl[i].er, tbl[i].ew, tbl[i].ea});
            if (!tbl[i].ed)
                chk($sformatf("vec%0d_dload", i), ccif.dload, LD);
            if (tbl[i].ew)
                chk($sformatf("vec%0d_store", i), ccif.ramstore, DS);
            tick();
        end

        // icache held while dcache keeps re-requesting
        drive(0, 0, 0, 0, FREE, IA, 32'h40, DS, LD);
        #4;
        tick();
        dn = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            drive(1, 1, 1, 0, ACCESS, IA, 32'h40, DS, LD);
            #4;
            if (!ccif.dwait) dn++;
            if (!ccif.iwait) begin
                got = 1'b1;
                chk("starve_dgrants", 256'(dn), 256'(SM));
                chk("starve_clr", 256'(dut.starve_q), 256'd0);
                chk("starve_iaddr", ccif.ramaddr, IA);
            end
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL starve_timeout act=no_igrant exp=igrant");
        end

        drive(0, 0, 0, 0, FREE, IA, 0, DS, LD);
        #4;
        tick();

        ir = 0; dr = 0; dw = 0;
        for (int c = 0; c < 800; c++) begin
            rn = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 99) < 20) ir = ~ir;
            if ($urandom_range(0, 99) < 20) dr = ~dr;
            if ($urandom_range(0, 99) < 15) dw = ~dw;
            rs = ramstate_t'($urandom_range(0, 3));
            ia = $urandom; da = $urandom; ds = $urandom; ld = $urandom;
            drive(rn, ir, dr, dw, rs, ia, da, ds, ld);
            #4;
            eiw = 1; edw = 1; err = 0; ewr = 0; ea = 0; es = 0;
            if (rn && m_own == 1) begin
                ea = da; es = ds; ewr = dw; err = dr & ~dw;
                edw = (rs != ACCESS);
            end else if (rn && m_own == 2) begin
                ea = ia; err = 1;
                eiw = (rs != ACCESS);
            end
            chk($sformatf("rand%0d", c),
                pack_out(ccif.iwait, ccif.dwait, ccif.ramREN,
                         ccif.ramWEN, ccif.ramaddr, ccif.ramstore,
                         ccif.iload, ccif.dload, ccif.ccwait,
                         ccif.ccinv, ccif.ccsnoopaddr),
                pack_out(eiw, edw, err, ewr, ea, es, ld, ld,
                         1'b0, 1'b0, 32'd0));
            chk($sformatf("rand%0d_starve", c),
                256'(dut.starve_q), 256'(m_k));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the number of consecutive dcache grants allowed while iREN is pending.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ccif  modport cache_control_if.cc  the memory-controller end of the caches' control interface.
REQ-005 SHALL take iREN, dREN, dWEN (1 each) and iaddr, daddr, dstore (word_t) as inputs from the caches.
REQ-006 SHALL drive iwait, dwait (1 each) and iload, dload (word_t) as outputs to the caches.
REQ-007 SHALL drive ramREN, ramWEN (1 each) and ramaddr, ramstore (word_t) as outputs to RAM.
REQ-008 SHALL take ramload (word_t) and ramstate (ramstate_t: FREE, BUSY, ACCESS, ERROR) as inputs from RAM.
REQ-009 SHALL tie the coherence outputs ccwait, ccinv and ccsnoopaddr to 0, and SHALL ignore the inputs ccwrite and cctrans.

Function
REQ-010 SHALL implement registered FSM states IDLE, DGRANT and IGRANT.
REQ-011 In IDLE, the FSM SHALL go to DGRANT if dREN|dWEN, else to IGRANT if iREN, else stay in IDLE.
REQ-012 In IDLE, if starve_cnt==STARVE_MAX and iREN, the FSM SHALL go to IGRANT regardless of any dcache request.
REQ-013 starve_cnt SHALL increment on each IDLE->DGRANT while iREN=1, clear on each IDLE->IGRANT, and saturate at STARVE_MAX.
REQ-014 In DGRANT, the block SHALL drive ramaddr=daddr, ramstore=dstore, ramREN=dREN and ramWEN=dWEN; dWEN has priority, so ramREN=0 when both are set.
REQ-015 In IGRANT, the block SHALL drive ramaddr=iaddr, ramREN=1 and ramWEN=0.
REQ-016 In IDLE, ramREN and ramWEN SHALL be 0, and ramaddr and ramstore SHALL be 0.
REQ-017 dwait SHALL be 0 only in DGRANT with ramstate==ACCESS (combinational), and 1 otherwise.
REQ-018 iwait SHALL be 0 only in IGRANT with ramstate==ACCESS, and 1 otherwise.
REQ-019 dload and iload SHALL both pass ramload unconditionally; each is valid only while its wait is low.
REQ-020 On ACCESS in a grant state, the FSM SHALL return to IDLE on the next edge, giving minimum latency of request -> wait low = 2 cycles and one IDLE bubble between transfers.
REQ-021 On FREE or BUSY, the FSM SHALL hold its grant state.
REQ-022 On ERROR, the FSM SHALL hold its grant state with the wait kept high, so RAM retries the transfer.
REQ-023 If the granted request drops before ACCESS (dREN|dWEN=0 in DGRANT, or iREN=0 in IGRANT), the FSM SHALL abort to IDLE on the next edge with no wait deasserted.
REQ-024 Simultaneous icache and dcache requests SHALL resolve per REQ-011/REQ-012 only; a grant SHALL never switch sources mid-transfer.
REQ-025 A request arriving in a grant state SHALL be evaluated only after the return to IDLE.

Reset
REQ-026 When nRST=0 at a clock edge, the block SHALL set state=IDLE and starve_cnt=0.
REQ-027 During reset, outputs SHALL be iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0 and ccwait=ccinv=ccsnoopaddr=0.
REQ-028 Reset asserted mid-transfer SHALL abandon that transfer, and no wait SHALL deassert in the following cycle.

Structure
REQ-029 The arb_state_t enum SHALL live in cpu_types_pkg beside ramstate_t and word_t; STARVE_MAX stays a module parameter.
REQ-030 The block SHALL be a single module with no sub-modules, comprising the next-state logic, the starvation counter and the output decode.

Verification
REQ-031 dREN=1, daddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> dwait low exactly 1 cycle with dload=0xDEADBEEF; iwait high throughout.
REQ-032 iREN and dWEN asserted together, dstore=0x12345678, daddr=0x80 -> RAM write to 0x80 first; then icache read of iaddr granted after 1 IDLE cycle.
REQ-033 iREN held and dREN re-asserted continuously -> after 4 dcache transfers the 5th grant goes to icache, and starve_cnt returns to 0.
REQ-034 ramstate=ERROR for 3 cycles then ACCESS during DGRANT -> dwait stays high through the errors and goes low only on ACCESS.
REQ-035 dREN dropped while in DGRANT and BUSY -> FSM returns to IDLE next cycle and ramREN=0; no dwait pulse.
REQ-036 nRST=0 asserted in IGRANT -> next cycle state=IDLE, iwait=1, ramREN=0; a request after reset release is granted normally.
